mask_encoder_32: RTL and testbench

Sequential 32-to-5 mask encoder for the register-file datapath, the inverse of the one-hot register-select decoders. It accepts a 32-bit register mask (multi-hot) via a valid/ready handshake, then emits the 5-bit index of every set bit, one per handshake. The last beat of each mask is flagged. It feeds index-driven logic such as the 5-bit write/read port selects for bulk register clear, save, and restore sequences.

---
 rtl/mask_enc_pkg.sv | 12 +
 rtl/prienc_32.sv | 31 +++
 rtl/mask_encoder_32.sv | 81 ++++++++
 tb/tb_mask_encoder_32.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mask_enc_pkg.sv
// Shared types and constants for the 32-bit register-mask encoder.
package mask_enc_pkg;

  localparam int MASK_W     = 32;
  localparam int MASK_IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/prienc_32.sv
// Combinational WIDTH-to-IDX_W priority encoder with a "one bit left" flag.
// Scan direction: MSB-first when MASK_ENC_MSB_FIRST_EN is defined, else LSB-first.
module prienc_32
  import mask_enc_pkg::*;
#(
  parameter  int WIDTH = MASK_W,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             one_left
);

  // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    idx = '0;
`ifdef MASK_ENC_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
`endif
  end

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign one_left = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/mask_encoder_32.sv
// Sequential mask encoder: accepts a multi-hot mask, emits one index per handshake.
// Emission order is descending when MASK_ENC_MSB_FIRST_EN is defined.
module mask_encoder_32
  import mask_enc_pkg::*;
#(
  parameter  int WIDTH = MASK_W,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             in_zero_q, in_zero_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_one_left;

  prienc_32 #(.WIDTH(WIDTH)) u_prienc (
    .vec      (pending_q),
    .idx      (enc_idx),
    .one_left (enc_one_left)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    in_zero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_mask != '0) begin
            pending_d = in_mask;
            state_d   = DRAIN;
          end else begin
            in_zero_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pending_d = pending_q & ~(WIDTH'(1) << enc_idx);
          if (enc_one_left) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      in_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      in_zero_q <= in_zero_d;
    end
  end

  // Outputs depend only on registered state, never on in_* or out_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_index = enc_idx;
  assign out_last  = (state_q == DRAIN) && enc_one_left;
  assign in_zero   = in_zero_q;

endmodule

// File: tb/tb_mask_encoder_32.sv
// Self-checking bench for mask_encoder_32: directed cases plus randomized masks
// checked against an index-list reference model.
module tb_mask_encoder_32;

  logic        clock;
  logic        ctrl_reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mask;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;

  int checks;
  int failures;

  mask_encoder_32 dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mask      (in_mask),
    .in_zero      (in_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: list of set-bit indices in emission order.
  function automatic void build_expected(input logic [31:0] m, output int q[$]);
    q = {};
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
`ifdef MASK_ENC_MSB_FIRST_EN
        q.push_front(i);
`else
        q.push_back(i);
`endif
      end
    end
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_in_ready"},  32'(in_ready),  1);
    check({tag, "_out_last"},  32'(out_last),  0);
  endtask

  // Accept a mask, then drain it. The first `hold` beats see out_ready low;
  // afterwards out_ready is high with probability rdy_pct percent.
  task automatic send(input logic [31:0] m, input int hold, input int rdy_pct);
    int q[$];
    int cycles;
    bit rdy;
    build_expected(m, q);
    @(negedge clock);
    check("accept_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_mask  = m;
    @(negedge clock);
    in_valid = 1'b0;
    in_mask  = $urandom;
    if (q.size() == 0) begin
      check("zero_pulse", 32'(in_zero), 1);
      check_idle("zero_first");
      @(negedge clock);
      check("zero_pulse_end", 32'(in_zero), 0);
      check_idle("zero_after");
      return;
    end
    check("no_zero_pulse", 32'(in_zero), 0);
    cycles = 0;
    while (q.size() > 0 && cycles < 300) begin
      check("beat_valid",    32'(out_valid), 1);
      check("beat_index",    32'(out_index), 32'(q[0]));
      check("beat_last",     32'(out_last),  32'(q.size() == 1));
      check("beat_busy",     32'(busy),      1);
      check("beat_in_ready", 32'(in_ready),  0);
      rdy = (cycles >= hold) && ($urandom_range(99) < rdy_pct);
      out_ready = rdy;
      // Noise on the input side must be ignored while draining.
      in_mask  = $urandom;
      in_valid = (rdy && q.size() == 1) ? 1'b0 : 1'($urandom_range(1));
      if (rdy) void'(q.pop_front());
      @(negedge clock);
      cycles++;
    end
    if (q.size() != 0) check("drain_timeout", 0, 1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_idle("post_drain");
  endtask

  initial begin
    logic [31:0] m;
    checks       = 0;
    failures     = 0;
    in_valid     = 1'b1;
    in_mask      = 32'hFFFF_FFFF;
    out_ready    = 1'b1;
    ctrl_reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_idle("reset");
    check("reset_in_zero",   32'(in_zero),   0);
    check("reset_out_index", 32'(out_index), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ctrl_reset_n = 1'b1;

    send(32'h0000_0001, 0, 100);
    send(32'h8000_0011, 0, 100);
    send(32'h0000_0C00, 3, 100);
    send(32'h0000_0000, 0, 100);

    // Reset in the middle of a drain.
    @(negedge clock);
    in_valid = 1'b1;
    in_mask  = 32'hFFFF_FFFF;
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("pre_reset_busy", 32'(busy), 1);
    ctrl_reset_n = 1'b0;
    #1;
    check_idle("mid_reset");
    @(negedge clock);
    out_ready    = 1'b0;
    ctrl_reset_n = 1'b1;
    send(32'h0000_0002, 0, 100);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(3))
        0:       m = 32'h0;
        1:       m = 32'(1) << $urandom_range(31);
        2:       m = $urandom & $urandom & $urandom;
        default: m = $urandom;
      endcase
      send(m, $urandom_range(2), $urandom_range(100, 30));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
